// File: rtl/reel_speed_sequencer.sv
// Drives a reel clock divider through idle -> accelerate -> spin -> decelerate.
// Speed ramps in SPEED_STEP increments once every STEP_CYCLES clocks.
module reel_speed_sequencer #(
  parameter int unsigned BASE_SPEED  = 50_000_000,
  parameter int unsigned MIN_SPEED   = 2,
  parameter int unsigned MAX_SPEED   = 20,
  parameter int unsigned SPEED_STEP  = 2,
  parameter int unsigned STEP_CYCLES = 5_000_000,
  parameter int unsigned SPIN_TICKS  = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop_req,
  output logic [31:0] speed,
  output logic        div_rst,
  output logic        busy,
  output logic        spinning,
  output logic        done
);

  if (MIN_SPEED == 0 || MAX_SPEED <= MIN_SPEED || SPEED_STEP == 0 ||
      STEP_CYCLES < 2 || SPIN_TICKS == 0 || MAX_SPEED > BASE_SPEED / 2) begin : g_param_check
    $error("reel_speed_sequencer: illegal parameter set");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCEL = 2'd1;
  localparam logic [1:0] S_SPIN  = 2'd2;
  localparam logic [1:0] S_DECEL = 2'd3;

  localparam logic [31:0] C_MIN       = MIN_SPEED;
  localparam logic [31:0] C_MAX       = MAX_SPEED;
  localparam logic [31:0] C_STEP      = SPEED_STEP;
  localparam logic [31:0] C_STEP_LAST = STEP_CYCLES - 1;
  localparam logic [31:0] C_SPIN_LAST = SPIN_TICKS - 1;

  logic [1:0]  r_state;
  logic [31:0] r_speed;
  logic [31:0] r_step_cnt;
  logic [31:0] r_spin_cnt;
  logic        r_stop_pending;
  logic        r_div_rst;
  logic        r_busy;
  logic        r_spinning;
  logic        r_done;

  logic [1:0]  w_state_nxt;
  logic        w_tick;
  logic [32:0] w_accel_sum;
  logic        w_accel_full;
  logic        w_decel_end;
  logic        w_spin_end;

  assign w_tick       = (r_state != S_IDLE) && (r_step_cnt == C_STEP_LAST);
  // 33-bit arithmetic keeps the ramp comparisons safe near the top of the 32-bit range
  assign w_accel_sum  = {1'b0, r_speed} + {1'b0, C_STEP};
  assign w_accel_full = w_accel_sum >= {1'b0, C_MAX};
  assign w_decel_end  = {1'b0, r_speed} <= ({1'b0, C_MIN} + {1'b0, C_STEP});
  assign w_spin_end   = r_stop_pending || (r_spin_cnt == C_SPIN_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_ACCEL;
      S_ACCEL: if (w_tick && w_accel_full) w_state_nxt = S_SPIN;
      S_SPIN:  if (w_tick && w_spin_end) w_state_nxt = S_DECEL;
      S_DECEL: if (w_tick && w_decel_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_speed        <= C_MIN;
      r_step_cnt     <= '0;
      r_spin_cnt     <= '0;
      r_stop_pending <= 1'b0;
      r_div_rst      <= 1'b1;
      r_busy         <= 1'b0;
      r_spinning     <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_div_rst  <= (w_state_nxt == S_IDLE);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_spinning <= (w_state_nxt == S_SPIN);
      r_done     <= (r_state == S_DECEL) && (w_state_nxt == S_IDLE);

      if (r_state == S_IDLE || w_tick) r_step_cnt <= '0;
      else                             r_step_cnt <= r_step_cnt + 32'd1;

      case (r_state)
        S_IDLE: begin
          r_speed <= C_MIN;
          if (start) r_stop_pending <= 1'b0;
        end
        S_ACCEL: begin
          // a stop seen here is remembered but the ramp still completes
          if (stop_req) r_stop_pending <= 1'b1;
          if (w_tick) begin
            if (w_accel_full) begin
              r_speed    <= C_MAX;
              r_spin_cnt <= '0;
            end else begin
              r_speed <= w_accel_sum[31:0];
            end
          end
        end
        S_SPIN: begin
          r_speed <= C_MAX;
          if (stop_req) r_stop_pending <= 1'b1;
          if (w_tick && !w_spin_end) r_spin_cnt <= r_spin_cnt + 32'd1;
        end
        S_DECEL: begin
          if (w_tick) begin
            if (w_decel_end) r_speed <= C_MIN;
            else             r_speed <= r_speed - C_STEP;
          end
        end
        default: r_speed <= C_MIN;
      endcase
    end
  end

  assign speed    = r_speed;
  assign div_rst  = r_div_rst;
  assign busy     = r_busy;
  assign spinning = r_spinning;
  assign done     = r_done;

endmodule

// File: tb/tb_reel_speed_sequencer.sv
// Scoreboard bench for reel_speed_sequencer: two instances with different ramp shapes.
// Stimulus queues expected output snapshots per edge; monitors pop and compare.
module tb_reel_speed_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_a, start_a, stop_a, div_rst_a, busy_a, spinning_a, done_a;
  logic [31:0] speed_a;
  logic        rst_b, start_b, stop_b, div_rst_b, busy_b, spinning_b, done_b;
  logic [31:0] speed_b;

  reel_speed_sequencer #(
    .BASE_SPEED(50_000_000), .MIN_SPEED(10), .MAX_SPEED(40), .SPEED_STEP(10),
    .STEP_CYCLES(4), .SPIN_TICKS(5)
  ) u_dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .stop_req(stop_a),
    .speed(speed_a), .div_rst(div_rst_a), .busy(busy_a), .spinning(spinning_a), .done(done_a)
  );

  reel_speed_sequencer #(
    .BASE_SPEED(50_000_000), .MIN_SPEED(3), .MAX_SPEED(20), .SPEED_STEP(7),
    .STEP_CYCLES(4), .SPIN_TICKS(5)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .stop_req(stop_b),
    .speed(speed_b), .div_rst(div_rst_b), .busy(busy_b), .spinning(spinning_b), .done(done_b)
  );

  typedef struct {
    int          cyc;
    logic [31:0] spd;
    logic        dr, bz, sp, dn;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int errors = 0;

  int ramp_a[4] = '{10, 20, 30, 40};
  int down_a[3] = '{30, 20, 10};
  int ramp_b[4] = '{3, 10, 17, 20};
  int down_b[3] = '{13, 6, 3};

  task automatic push(input bit b, input int c, input int s,
                      input bit dr, input bit bz, input bit sp, input bit dn);
    exp_t e;
    e.cyc = c; e.spd = s; e.dr = dr; e.bz = bz; e.sp = sp; e.dn = dn;
    if (b) qb.push_back(e);
    else   qa.push_back(e);
  endtask

  // Expected snapshots for one spin started at edge e0 with DECEL entered at edge dec.
  task automatic push_spin(input bit b, input int e0, input int ramp[4], input int dec,
                           input int down[3], input bit idle_after);
    push(b, e0,      ramp[0], 0, 1, 0, 0);
    push(b, e0 + 3,  ramp[0], 0, 1, 0, 0);
    push(b, e0 + 4,  ramp[1], 0, 1, 0, 0);
    push(b, e0 + 8,  ramp[2], 0, 1, 0, 0);
    push(b, e0 + 11, ramp[2], 0, 1, 0, 0);
    push(b, e0 + 12, ramp[3], 0, 1, 1, 0);
    push(b, dec - 1, ramp[3], 0, 1, 1, 0);
    push(b, dec,     ramp[3], 0, 1, 0, 0);
    push(b, dec + 4, down[0], 0, 1, 0, 0);
    push(b, dec + 8, down[1], 0, 1, 0, 0);
    push(b, dec + 11, down[1], 0, 1, 0, 0);
    push(b, dec + 12, down[2], 1, 0, 0, 1);
    if (idle_after) push(b, dec + 13, down[2], 1, 0, 0, 0);
  endtask

  task automatic cmp(input string nm, input exp_t e, input logic [31:0] spd,
                     input logic dr, input logic bz, input logic sp, input logic dn);
    checks++;
    if (e.cyc != cyc || spd !== e.spd || dr !== e.dr || bz !== e.bz || sp !== e.sp || dn !== e.dn) begin
      errors++;
      $display("FAIL %s cyc=%0d (expected at %0d): got spd=%0d div_rst=%b busy=%b spinning=%b done=%b, expected spd=%0d div_rst=%b busy=%b spinning=%b done=%b",
               nm, cyc, e.cyc, spd, dr, bz, sp, dn, e.spd, e.dr, e.bz, e.sp, e.dn);
    end
  endtask

  bit done_ok_a, done_ok_b;

  always @(negedge clk) begin
    exp_t e;
    done_ok_a = 1'b0;
    while (qa.size() > 0 && qa[0].cyc <= cyc) begin
      e = qa.pop_front();
      cmp("dut_a", e, speed_a, div_rst_a, busy_a, spinning_a, done_a);
      if (e.dn) done_ok_a = 1'b1;
    end
    if (done_a === 1'b1 && !done_ok_a) begin
      checks++; errors++;
      $display("FAIL dut_a unexpected done at cyc=%0d: got done=1, expected done=0", cyc);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    done_ok_b = 1'b0;
    while (qb.size() > 0 && qb[0].cyc <= cyc) begin
      e = qb.pop_front();
      cmp("dut_b", e, speed_b, div_rst_b, busy_b, spinning_b, done_b);
      if (e.dn) done_ok_b = 1'b1;
    end
    if (done_b === 1'b1 && !done_ok_b) begin
      checks++; errors++;
      $display("FAIL dut_b unexpected done at cyc=%0d: got done=1, expected done=0", cyc);
    end
  end

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete by time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1;
    rst_a = 1'b0; start_a = 1'b1; stop_a = 1'b0;
    rst_b = 1'b0; start_b = 1'b0; stop_b = 1'b0;

    // reset held with start high, then released into a full spin
    for (int k = 1; k <= 3; k++) push(0, k, 10, 1, 0, 0, 0);
    wait_until(3);
    rst_a = 1'b1; rst_b = 1'b1;
    e0 = cyc + 1;
    push_spin(0, e0, ramp_a, e0 + 32, down_a, 1);
    wait_until(e0); start_a = 1'b0;
    wait_until(e0 + 46);

    // early stop during SPIN
    e0 = cyc + 1; start_a = 1'b1;
    push_spin(0, e0, ramp_a, e0 + 16, down_a, 1);
    wait_until(e0); start_a = 1'b0;
    wait_until(e0 + 13); stop_a = 1'b1;
    wait_until(e0 + 14); stop_a = 1'b0;
    wait_until(e0 + 32);

    // stop during ACCEL: ramp completes, then one SPIN tick
    e0 = cyc + 1; start_a = 1'b1;
    push_spin(0, e0, ramp_a, e0 + 16, down_a, 1);
    wait_until(e0); start_a = 1'b0;
    wait_until(e0 + 4); stop_a = 1'b1;
    wait_until(e0 + 5); stop_a = 1'b0;
    wait_until(e0 + 32);

    // uneven step, ignored mid-spin start, back-to-back restart in the done cycle
    e0 = cyc + 1; start_b = 1'b1;
    e1 = e0 + 45;
    push_spin(1, e0, ramp_b, e0 + 32, down_b, 0);
    push_spin(1, e1, ramp_b, e1 + 32, down_b, 1);
    wait_until(e0); start_b = 1'b0;
    wait_until(e0 + 17); start_b = 1'b1;
    wait_until(e0 + 18); start_b = 1'b0;
    wait_until(e0 + 43); start_b = 1'b1;
    wait_until(e1); start_b = 1'b0;
    wait_until(e1 + 46);

    // reset during ACCEL with a stop pending
    e0 = cyc + 1; start_a = 1'b1;
    push(0, e0,      10, 0, 1, 0, 0);
    push(0, e0 + 4,  20, 0, 1, 0, 0);
    push(0, e0 + 8,  30, 0, 1, 0, 0);
    push(0, e0 + 10, 10, 1, 0, 0, 0);
    push(0, e0 + 11, 10, 1, 0, 0, 0);
    wait_until(e0); start_a = 1'b0;
    wait_until(e0 + 4); stop_a = 1'b1;
    wait_until(e0 + 5); stop_a = 1'b0;
    wait_until(e0 + 9); rst_a = 1'b0;
    wait_until(e0 + 10); rst_a = 1'b1;
    wait_until(e0 + 13);

    // reset during SPIN on a tick edge
    e0 = cyc + 1; start_a = 1'b1;
    push(0, e0,      10, 0, 1, 0, 0);
    push(0, e0 + 4,  20, 0, 1, 0, 0);
    push(0, e0 + 8,  30, 0, 1, 0, 0);
    push(0, e0 + 12, 40, 0, 1, 1, 0);
    push(0, e0 + 19, 40, 0, 1, 1, 0);
    push(0, e0 + 20, 10, 1, 0, 0, 0);
    push(0, e0 + 21, 10, 1, 0, 0, 0);
    wait_until(e0); start_a = 1'b0;
    wait_until(e0 + 19); rst_a = 1'b0;
    wait_until(e0 + 20); rst_a = 1'b1;
    wait_until(e0 + 23);

    // following spin must run the full five SPIN ticks
    e0 = cyc + 1; start_a = 1'b1;
    push_spin(0, e0, ramp_a, e0 + 32, down_a, 1);
    wait_until(e0); start_a = 1'b0;
    wait_until(e0 + 50);

    while (qa.size() > 0) begin
      exp_t e;
      e = qa.pop_front();
      checks++; errors++;
      $display("FAIL dut_a never checked: expected spd=%0d at cyc=%0d, got no sample", e.spd, e.cyc);
    end
    while (qb.size() > 0) begin
      exp_t e;
      e = qb.pop_front();
      checks++; errors++;
      $display("FAIL dut_b never checked: expected spd=%0d at cyc=%0d, got no sample", e.spd, e.cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
